// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Imported by the arbiter top and its round-robin selector.
package sevenseg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam int NREQ  = 4;
    localparam int IDX_W = 2;
    localparam int VAL_W = 16;

    localparam logic [VAL_W-1:0] IDLE_VALUE_DEF = 16'h0000;

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return NREQ'(1) << i;
    endfunction

endpackage

// File: rtl/sevenseg_arbiter_rr_pick4.sv
// Combinational round-robin pick: first set request bit
// scanning ptr, ptr+1, ... modulo four.
module rr_pick4
    import sevenseg_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] sel
);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest slot back so the nearest hit wins.
    always_comb begin
        any = |req;
        sel = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + IDX_W'(k);
            if (req[idx]) sel = idx;
        end
    end

endmodule

// File: rtl/sevenseg_arbiter.sv
// Round-robin sharing of one 4-digit hex display between four
// requesters with a minimum dwell time per grant.
module sevenseg_arbiter
    import sevenseg_pkg::*;
#(
    parameter int                  DWELL_W    = 24,
    parameter logic [DWELL_W-1:0]  DWELL      = 24'd12000000,
    parameter logic [VAL_W-1:0]    IDLE_VALUE = IDLE_VALUE_DEF
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*VAL_W-1:0] data,
    input  logic                 freeze,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      ack,
    output logic [VAL_W-1:0]     value,
    output logic [IDX_W-1:0]     active_id
);

    localparam logic [DWELL_W-1:0] RELOAD = DWELL - DWELL_W'(1);

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [DWELL_W-1:0] dwell;
    logic               track;

    logic               any;
    logic [IDX_W-1:0]   sel;
    logic [VAL_W-1:0]   src [NREQ];
    logic               expire;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            src[i] = data[VAL_W*i +: VAL_W];
        end
    end

    assign expire = (dwell == '0) && !freeze;

    rr_pick4 u_pick (
        .req (req),
        .ptr (rr_ptr),
        .any (any),
        .sel (sel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            ack       <= '0;
            value     <= IDLE_VALUE;
            active_id <= '0;
            rr_ptr    <= '0;
            dwell     <= '0;
            track     <= 1'b0;
        end else begin
            ack <= '0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        state     <= SHOW;
                        grant     <= onehot(sel);
                        ack       <= onehot(sel);
                        value     <= src[sel];
                        active_id <= sel;
                        dwell     <= RELOAD;
                        track     <= 1'b1;
                        rr_ptr    <= sel + IDX_W'(1);
                    end else begin
                        value <= IDLE_VALUE;
                    end
                end
                SHOW: begin
                    if (expire) begin
                        if (!any) begin
                            state     <= IDLE;
                            grant     <= '0;
                            value     <= IDLE_VALUE;
                            active_id <= '0;
                            track     <= 1'b0;
                        end else begin
                            // Re-grant of the same source keeps grant high, no ack.
                            grant     <= onehot(sel);
                            value     <= src[sel];
                            active_id <= sel;
                            dwell     <= RELOAD;
                            track     <= 1'b1;
                            rr_ptr    <= sel + IDX_W'(1);
                            if (sel != active_id) ack <= onehot(sel);
                        end
                    end else begin
                        if (!freeze) dwell <= dwell - DWELL_W'(1);
                        if (!req[active_id]) begin
                            track <= 1'b0;
                        end else if (track) begin
                            value <= src[active_id];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sevenseg_arbiter.sv
// Scoreboard bench for sevenseg_arbiter with DWELL=4.
// Stimulus queues expected outputs; a monitor pops and compares.
module tb_sevenseg_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] d [4];
    logic [63:0] data;
    logic        freeze = 1'b0;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [15:0] value;
    logic [1:0]  active_id;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  g;
        logic [3:0]  a;
        logic [15:0] v;
        logic [1:0]  id;
    } exp_t;

    exp_t sb [$];
    event sample_ev;

    assign data = {d[3], d[2], d[1], d[0]};

    always #5 clk = ~clk;

    sevenseg_arbiter #(
        .DWELL_W    (24),
        .DWELL      (24'd4),
        .IDLE_VALUE (16'h0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data      (data),
        .freeze    (freeze),
        .grant     (grant),
        .ack       (ack),
        .value     (value),
        .active_id (active_id)
    );

    always @(negedge clk) -> sample_ev;

    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (grant !== e.g || ack !== e.a ||
                    value !== e.v || active_id !== e.id) begin
                    errors++;
                    $display("FAIL %s: got g=%b a=%b v=%h id=%0d, need g=%b a=%b v=%h id=%0d",
                             e.name, grant, ack, value, active_id,
                             e.g, e.a, e.v, e.id);
                end
            end
        end
    end

    task automatic push(input string nm, input logic [3:0] eg,
                        input logic [3:0] ea, input logic [15:0] ev,
                        input logic [1:0] eid);
        exp_t e;
        e.name = nm;
        e.g = eg;
        e.a = ea;
        e.v = ev;
        e.id = eid;
        sb.push_back(e);
    endtask

    task automatic step(input string nm, input logic [3:0] r,
                        input logic f, input logic [3:0] eg,
                        input logic [3:0] ea, input logic [15:0] ev,
                        input logic [1:0] eid);
        req = r;
        freeze = f;
        @(posedge clk);
        push(nm, eg, ea, ev, eid);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        req = '0;
        freeze = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, need finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4; i++) d[i] = '0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 20; i++)
            step("idle", 4'b0000, 1'b0, 4'b0000, 4'b0000, 16'h0000, 2'd0);

        d[1] = 16'hBEEF;
        step("s1_new", 4'b0010, 1'b0, 4'b0010, 4'b0010, 16'hBEEF, 2'd1);
        step("s1_hold", 4'b0010, 1'b0, 4'b0010, 4'b0000, 16'hBEEF, 2'd1);
        d[1] = 16'h1234;
        step("s1_live", 4'b0010, 1'b0, 4'b0010, 4'b0000, 16'h1234, 2'd1);
        step("s1_last", 4'b0010, 1'b0, 4'b0010, 4'b0000, 16'h1234, 2'd1);
        step("s1_idle", 4'b0000, 1'b0, 4'b0000, 4'b0000, 16'h0000, 2'd0);

        pulse_reset();
        for (int i = 0; i < 4; i++) d[i] = 16'(i);
        for (int g = 0; g < 5; g++) begin
            step("rr_new", 4'b1111, 1'b0, 4'(1 << (g % 4)),
                 4'(1 << (g % 4)), 16'(g % 4), 2'(g % 4));
            for (int k = 0; k < 3; k++)
                step("rr_hold", 4'b1111, 1'b0, 4'(1 << (g % 4)),
                     4'b0000, 16'(g % 4), 2'(g % 4));
        end

        pulse_reset();
        d[2] = 16'hCAFE;
        step("drop_new", 4'b0100, 1'b0, 4'b0100, 4'b0100, 16'hCAFE, 2'd2);
        d[2] = 16'h5555;
        for (int i = 0; i < 3; i++)
            step("drop_hold", 4'b0000, 1'b0, 4'b0100, 4'b0000, 16'hCAFE, 2'd2);
        step("drop_idle", 4'b0000, 1'b0, 4'b0000, 4'b0000, 16'h0000, 2'd0);

        d[3] = 16'h0303;
        step("s3_new", 4'b1000, 1'b0, 4'b1000, 4'b1000, 16'h0303, 2'd3);
        for (int i = 0; i < 11; i++)
            step("s3_keep", 4'b1000, 1'b0, 4'b1000, 4'b0000, 16'h0303, 2'd3);
        step("s3_idle", 4'b0000, 1'b0, 4'b0000, 4'b0000, 16'h0000, 2'd0);

        d[0] = 16'hA0A0;
        step("fz_new", 4'b0001, 1'b0, 4'b0001, 4'b0001, 16'hA0A0, 2'd0);
        step("fz_pre", 4'b0001, 1'b0, 4'b0001, 4'b0000, 16'hA0A0, 2'd0);
        for (int i = 0; i < 10; i++)
            step("fz_hold", 4'b0001, 1'b1, 4'b0001, 4'b0000, 16'hA0A0, 2'd0);
        step("fz_post", 4'b0001, 1'b0, 4'b0001, 4'b0000, 16'hA0A0, 2'd0);
        step("fz_post", 4'b0001, 1'b0, 4'b0001, 4'b0000, 16'hA0A0, 2'd0);
        step("fz_idle", 4'b0000, 1'b0, 4'b0000, 4'b0000, 16'h0000, 2'd0);

        d[0] = 16'h0F0F;
        step("ar_new", 4'b0001, 1'b0, 4'b0001, 4'b0001, 16'h0F0F, 2'd0);
        step("ar_hold", 4'b0001, 1'b0, 4'b0001, 4'b0000, 16'h0F0F, 2'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        push("async_rst", 4'b0000, 4'b0000, 16'h0000, 2'd0);
        -> sample_ev;
        #1;
        @(posedge clk);
        #1 reset = 1'b0;
        req = '0;

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending, need 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
